link_selftest: RTL and testbench

Parametrised successor to the single-pattern sender/receiver test harness for the FPGA-to-FPGA parallel link.
- Contains a pattern generator, a TX 4-phase req/ack/rdy engine, an RX 4-phase engine and an on-the-fly checker.
- Counts words sent and received and flags errors. Drives a pass LED.
- Sits at FPGA top level, between the link pins and board I/O. Usable in external loopback or across two boards.

---
 rtl/link_selftest_pkg.sv | 31 +++
 rtl/link_pattern_gen.sv | 63 ++++++
 rtl/link_selftest.sv | 239 +++++++++++++++++++++++
 tb/tb_link_selftest.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_selftest_pkg.sv
// Shared types and constants for the parallel-link self-test harness.
package link_selftest_pkg;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned PATTERN_INCR = 0;
    localparam int unsigned PATTERN_LFSR = 1;

    // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        TxIdle,
        TxWaitRdy,
        TxSetup,
        TxReq,
        TxRelease,
        TxDone
    } tx_state_t;

    typedef enum logic [1:0] {
        RxIdle,
        RxWait,
        RxAck,
        RxDone
    } rx_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/link_pattern_gen.sv
// Test pattern source: incrementing counter or 32-bit LFSR, replicated to DATA_W.
module link_pattern_gen
    import link_selftest_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PATTERN = PATTERN_INCR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    if (PATTERN == PATTERN_LFSR) begin : g_lfsr
        logic [31:0] lfsr_q;
        logic [31:0] seed32;

        if (DATA_W >= 32) begin : g_wide
            assign seed32 = seed[31:0];
            if (DATA_W > 32) begin : g_extra
                logic unused_seed;
                assign unused_seed = ^seed[DATA_W-1:32];
            end
        end else begin : g_narrow
            logic unused_lfsr;
            assign seed32      = 32'(seed);
            assign unused_lfsr = ^lfsr_q[31:DATA_W];
        end

        // LFSR state; an all-zero seed would lock up, so it is replaced by 1
        always_ff @(posedge clk) begin
            if (!rst) begin
                lfsr_q <= '0;
            end else if (load) begin
                lfsr_q <= (seed32 == 32'd0) ? 32'd1 : seed32;
            end else if (advance) begin
                lfsr_q <= lfsr_next(lfsr_q);
            end
        end

        for (genvar i = 0; i < DATA_W; i++) begin : g_rep
            assign value[i] = lfsr_q[i % 32];
        end
    end else begin : g_incr
        logic [DATA_W-1:0] cnt_q;

        // Incrementing pattern, wraps modulo 2^DATA_W
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (load) begin
                cnt_q <= seed;
            end else if (advance) begin
                cnt_q <= cnt_q + DATA_W'(1);
            end
        end

        assign value = cnt_q;
    end

endmodule

// File: rtl/link_selftest.sv
// Parallel-link self-test: pattern TX and checking RX over 4-phase req/ack/rdy.
// Optional watchdog enabled by defining LINK_SELFTEST_TIMEOUT_EN.
module link_selftest
    import link_selftest_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORD_COUNT     = 100,
    parameter int unsigned PATTERN        = PATTERN_INCR,
    parameter logic [63:0] SEED           = 64'd1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [DATA_W-1:0] data_out,
    output logic              req_out,
    input  logic              rdy_in,
    input  logic              ack_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              req_in,
    output logic              ack_out,
    output logic              rdy_out,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              led
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(WORD_COUNT);

    logic rdy_meta_q, rdy_sync_q, ack_meta_q, ack_sync_q, req_meta_q, req_sync_q;
    logic en_prev_q, start, wd_hit, tx_adv, rx_adv;
    tx_state_t tx_state_q, tx_state_d;
    rx_state_t rx_state_q, rx_state_d;
    logic [DATA_W-1:0] data_q, data_d, tx_pat, rx_exp;
    logic req_q, req_d, ack_q, ack_d, rdy_q, rdy_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic [CNT_W-1:0] err_q, err_d, first_idx_q, first_idx_d;
    logic done_q, done_d, pass_q, pass_d, timeout_q, timeout_d, both_done;

    assign start = (tx_state_q inside {TxIdle, TxDone}) && (rx_state_q inside {RxIdle, RxDone})
                   && en && !en_prev_q;
    assign both_done = (tx_state_q == TxDone) && (rx_state_q == RxDone);

    link_pattern_gen #(.DATA_W(DATA_W), .PATTERN(PATTERN)) u_tx_gen (
        .clk(clk), .rst(rst), .load(start), .seed(SEED[DATA_W-1:0]), .advance(tx_adv),
        .value(tx_pat)
    );

    link_pattern_gen #(.DATA_W(DATA_W), .PATTERN(PATTERN)) u_rx_gen (
        .clk(clk), .rst(rst), .load(start), .seed(SEED[DATA_W-1:0]), .advance(rx_adv),
        .value(rx_exp)
    );

    // Two-flop synchronisers for the far-end handshake lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            {rdy_meta_q, rdy_sync_q, ack_meta_q, ack_sync_q, req_meta_q, req_sync_q} <= '0;
        end else begin
            rdy_meta_q <= rdy_in;
            rdy_sync_q <= rdy_meta_q;
            ack_meta_q <= ack_in;
            ack_sync_q <= ack_meta_q;
            req_meta_q <= req_in;
            req_sync_q <= req_meta_q;
        end
    end

`ifdef LINK_SELFTEST_TIMEOUT_EN
    logic [31:0] tx_wd_q, rx_wd_q;
    logic tx_waiting, rx_waiting;
    assign tx_waiting = tx_state_q inside {TxWaitRdy, TxReq, TxRelease};
    assign rx_waiting = rx_state_q inside {RxWait, RxAck};
    assign wd_hit = (tx_waiting && (tx_wd_q == TIMEOUT_CYCLES - 1))
                    || (rx_waiting && (rx_wd_q == TIMEOUT_CYCLES - 1));

    // Per-FSM watchdogs, restarted on every state change
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wd_q <= '0;
            rx_wd_q <= '0;
        end else begin
            tx_wd_q <= (tx_state_d != tx_state_q || !tx_waiting) ? '0 : tx_wd_q + 32'd1;
            rx_wd_q <= (rx_state_d != rx_state_q || !rx_waiting) ? '0 : rx_wd_q + 32'd1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign wd_hit         = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_prev_q   <= 1'b0;
            tx_state_q  <= TxIdle;
            rx_state_q  <= RxIdle;
            data_q      <= '0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            rdy_q       <= 1'b0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            en_prev_q   <= en;
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            data_q      <= data_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            rdy_q       <= rdy_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            err_q       <= err_d;
            first_idx_q <= first_idx_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    // TX handshake: present data, raise req, wait ack, drop req, wait ack release
    always_comb begin
        tx_state_d = tx_state_q;
        data_d     = data_q;
        req_d      = req_q;
        tx_count_d = tx_count_q;
        tx_adv     = 1'b0;
        if (start) begin
            tx_state_d = TxWaitRdy;
            req_d      = 1'b0;
            tx_count_d = '0;
        end else begin
            unique case (tx_state_q)
                TxWaitRdy: if (rdy_sync_q) begin
                    data_d     = tx_pat;
                    tx_state_d = TxSetup;
                end
                TxSetup: begin
                    req_d      = 1'b1;
                    tx_state_d = TxReq;
                end
                TxReq: if (ack_sync_q) begin
                    req_d      = 1'b0;
                    tx_count_d = tx_count_q + 1'b1;
                    tx_adv     = 1'b1;
                    tx_state_d = TxRelease;
                end
                TxRelease: if (!ack_sync_q) begin
                    tx_state_d = (tx_count_q == LastCount) ? TxDone : TxWaitRdy;
                end
                default: ;
            endcase
        end
        if (wd_hit) begin
            tx_state_d = TxDone;
            req_d      = 1'b0;
        end
    end

    // RX handshake and on-the-fly compare against the expected pattern
    always_comb begin
        rx_state_d  = rx_state_q;
        ack_d       = ack_q;
        rdy_d       = rdy_q;
        rx_count_d  = rx_count_q;
        err_d       = err_q;
        first_idx_d = first_idx_q;
        rx_adv      = 1'b0;
        if (start) begin
            rx_state_d  = RxWait;
            rdy_d       = 1'b1;
            ack_d       = 1'b0;
            rx_count_d  = '0;
            err_d       = '0;
            first_idx_d = '0;
        end else begin
            unique case (rx_state_q)
                RxWait: if (req_sync_q) begin
                    ack_d      = 1'b1;
                    rdy_d      = 1'b0;
                    rx_state_d = RxAck;
                    if (data_in != rx_exp) begin
                        if (err_q != '1) err_d = err_q + 1'b1;
                        if (err_q == '0) first_idx_d = rx_count_q;
                    end
                end
                RxAck: if (!req_sync_q) begin
                    ack_d      = 1'b0;
                    rx_count_d = rx_count_q + 1'b1;
                    rx_adv     = 1'b1;
                    if (rx_count_d == LastCount) begin
                        rx_state_d = RxDone;
                    end else begin
                        rx_state_d = RxWait;
                        rdy_d      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (wd_hit) begin
            rx_state_d = RxDone;
            ack_d      = 1'b0;
            rdy_d      = 1'b0;
        end
    end

    // Run status, registered one cycle after both FSMs finish
    always_comb begin
        done_d    = !start && both_done;
        pass_d    = done_d && (err_q == '0) && !timeout_q;
        timeout_d = !start && (timeout_q || wd_hit);
    end

    assign data_out      = data_q;
    assign req_out       = req_q;
    assign ack_out       = ack_q;
    assign rdy_out       = rdy_q;
    assign tx_count      = tx_count_q;
    assign rx_count      = rx_count_q;
    assign err_count     = err_q;
    assign first_err_idx = first_idx_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign led           = pass_q;

endmodule

// File: tb/tb_link_selftest.sv
// Bench for link_selftest: two looped-back instances (incrementing and LFSR).
// Timeout scenario is compiled in when LINK_SELFTEST_TIMEOUT_EN is defined.
module tb_link_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        rdy_gate = 1'b1, ack_gate = 1'b1, rnd_stall = 1'b0;
    logic [3:0]  corrupt_set = 4'd0;
    logic [31:0] corrupt_mask = 32'd0;

    logic [31:0] data_out_a, data_in_a, data_out_b;
    logic        req_out_a, ack_out_a, rdy_out_a, done_a, pass_a, timeout_a, led_a;
    logic        req_out_b, ack_out_b, rdy_out_b, done_b, pass_b, timeout_b, led_b;
    logic [15:0] tx_count_a, rx_count_a, err_count_a, first_err_idx_a;
    logic [15:0] tx_count_b, rx_count_b, err_count_b, first_err_idx_b;

    // Loopback with bench-controlled corruption and gating on instance A
    assign data_in_a = data_out_a ^ (corrupt_set[tx_count_a[1:0]] ? corrupt_mask : 32'd0);

    link_selftest #(
        .DATA_W(32), .WORD_COUNT(4), .PATTERN(0), .SEED(64'h10), .TIMEOUT_CYCLES(64)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .data_out(data_out_a), .req_out(req_out_a),
        .rdy_in(rdy_out_a & rdy_gate), .ack_in(ack_out_a & ack_gate),
        .data_in(data_in_a), .req_in(req_out_a),
        .ack_out(ack_out_a), .rdy_out(rdy_out_a),
        .tx_count(tx_count_a), .rx_count(rx_count_a), .err_count(err_count_a),
        .first_err_idx(first_err_idx_a), .done(done_a), .pass(pass_a),
        .timeout(timeout_a), .led(led_a)
    );

    link_selftest #(
        .DATA_W(32), .WORD_COUNT(8), .PATTERN(1), .SEED(64'h0), .TIMEOUT_CYCLES(1024)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .data_out(data_out_b), .req_out(req_out_b),
        .rdy_in(rdy_out_b), .ack_in(ack_out_b),
        .data_in(data_out_b), .req_in(req_out_b),
        .ack_out(ack_out_b), .rdy_out(rdy_out_b),
        .tx_count(tx_count_b), .rx_count(rx_count_b), .err_count(err_count_b),
        .first_err_idx(first_err_idx_b), .done(done_b), .pass(pass_b),
        .timeout(timeout_b), .led(led_b)
    );

    int checks = 0;
    int errors = 0;

    // Words put on the link, captured when req rises
    logic [31:0] sent_a[$], sent_b[$];
    logic        req_prev_a = 1'b0, req_prev_b = 1'b0;
    always @(negedge clk) begin
        if (req_out_a && !req_prev_a) sent_a.push_back(data_out_a);
        if (req_out_b && !req_prev_b) sent_b.push_back(data_out_b);
        req_prev_a = req_out_a;
        req_prev_b = req_out_b;
    end

    // Reference LFSR: word n of a run seeded with 0 (replaced by 1)
    function automatic logic [31:0] lfsr_word(input int unsigned n);
        logic [31:0] s;
        logic [31:0] fb;
        s = 32'd1;
        for (int k = 0; k < int'(n); k++) begin
            fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1;
            s  = (s << 1) | fb;
        end
        return s;
    endfunction

    task automatic start_run(input bit sel);
        if (sel) sent_b.delete(); else sent_a.delete();
        if (sel) en_b = 1'b1; else en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel ? done_b : done_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (rnd_stall) rdy_gate = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rdy_gate = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({data_out_a, req_out_a, ack_out_a, rdy_out_a, tx_count_a, rx_count_a,
                 err_count_a, first_err_idx_a, done_a, pass_a, timeout_a, led_a} !== '0) begin
                errors++;
                $display("FAIL reset_a cycle %0d: req=%b ack=%b rdy=%b data=%h done=%b, want all 0",
                         c, req_out_a, ack_out_a, rdy_out_a, data_out_a, done_a);
            end
            checks++;
            if ({data_out_b, req_out_b, ack_out_b, rdy_out_b, done_b, pass_b, led_b} !== '0) begin
                errors++;
                $display("FAIL reset_b cycle %0d: req=%b data=%h, want all 0",
                         c, req_out_b, data_out_b);
            end
        end
        en_a = 1'b0;
        en_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Clean run, word-2 bit-0 flip, then random corruption sets under random backpressure
    task automatic test_loopback();
        bit          ok;
        int          exp_err;
        int          exp_idx;
        logic [31:0] got;
        for (int it = 0; it < 6; it++) begin
            corrupt_set  = (it == 0) ? 4'd0 : (it == 1) ? 4'b0100 : 4'($urandom);
            corrupt_mask = (it == 1) ? 32'd1 : ($urandom | 32'd1);
            rnd_stall    = (it >= 2);
            exp_err = 0;
            exp_idx = -1;
            for (int w = 0; w < 4; w++) begin
                if (corrupt_set[w]) begin
                    exp_err++;
                    if (exp_idx < 0) exp_idx = w;
                end
            end
            if (exp_idx < 0) exp_idx = 0;
            start_run(1'b0);
            wait_done(1'b0, 2000, ok);
            rnd_stall = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL loop%0d done: got %b expected 1 within budget", it, done_a);
            end
            checks++;
            if (tx_count_a !== 16'd4 || rx_count_a !== 16'd4) begin
                errors++;
                $display("FAIL loop%0d counts: got tx=%0d rx=%0d expected 4/4",
                         it, tx_count_a, rx_count_a);
            end
            checks++;
            if (err_count_a !== 16'(exp_err) || first_err_idx_a !== 16'(exp_idx)) begin
                errors++;
                $display("FAIL loop%0d errors: got err=%0d idx=%0d expected err=%0d idx=%0d",
                         it, err_count_a, first_err_idx_a, exp_err, exp_idx);
            end
            checks++;
            if (pass_a !== (exp_err == 0) || led_a !== (exp_err == 0) || timeout_a !== 1'b0) begin
                errors++;
                $display("FAIL loop%0d status: got pass=%b led=%b timeout=%b expected pass=%b",
                         it, pass_a, led_a, timeout_a, exp_err == 0);
            end
            for (int w = 0; w < 4; w++) begin
                got = (w < sent_a.size()) ? sent_a[w] : 32'hxxxx_xxxx;
                checks++;
                if (got !== 32'h10 + 32'(w)) begin
                    errors++;
                    $display("FAIL loop%0d word%0d: got %h expected %h", it, w, got, 32'h10 + w);
                end
            end
        end
        corrupt_set = 4'd0;
    endtask

    task automatic test_lfsr();
        bit          ok;
        logic [31:0] got;
        start_run(1'b1);
        wait_done(1'b1, 3000, ok);
        checks++;
        if (!ok || pass_b !== 1'b1 || led_b !== 1'b1 || err_count_b !== 16'd0) begin
            errors++;
            $display("FAIL lfsr status: got done=%b pass=%b led=%b err=%0d expected 1/1/1/0",
                     done_b, pass_b, led_b, err_count_b);
        end
        checks++;
        if (tx_count_b !== 16'd8 || rx_count_b !== 16'd8) begin
            errors++;
            $display("FAIL lfsr counts: got tx=%0d rx=%0d expected 8/8", tx_count_b, rx_count_b);
        end
        for (int w = 0; w < 8; w++) begin
            got = (w < sent_b.size()) ? sent_b[w] : 32'hxxxx_xxxx;
            checks++;
            if (got !== lfsr_word(w)) begin
                errors++;
                $display("FAIL lfsr word%0d: got %h expected %h", w, got, lfsr_word(w));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit saw_req;
        rdy_gate = 1'b0;
        start_run(1'b0);
        saw_req = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (req_out_a !== 1'b0) saw_req = 1'b1;
            if (c < 49) @(negedge clk);
        end
        checks++;
        if (saw_req) begin
            errors++;
            $display("FAIL backpressure req_out: got 1 during stall expected 0");
        end
        rdy_gate = 1'b1;
        wait_done(1'b0, 2000, ok);
        checks++;
        if (!ok || pass_a !== 1'b1 || tx_count_a !== 16'd4 || rx_count_a !== 16'd4) begin
            errors++;
            $display("FAIL backpressure run: got done=%b pass=%b tx=%0d rx=%0d expected 1/1/4/4",
                     done_a, pass_a, tx_count_a, rx_count_a);
        end
    endtask

    task automatic test_midrun_reset();
        bit ok;
        ok = 1'b0;
        start_run(1'b0);
        for (int c = 0; c < 1000; c++) begin
            if (req_out_a === 1'b1 && tx_count_a === 16'd2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrun reach_word2: got req=%b tx=%0d expected req=1 tx=2",
                     req_out_a, tx_count_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_out_a, ack_out_a, rdy_out_a, done_a} !== 4'b0
            || tx_count_a !== 16'd0 || rx_count_a !== 16'd0) begin
            errors++;
            $display("FAIL midrun reset: got req=%b ack=%b tx=%0d rx=%0d expected all 0",
                     req_out_a, ack_out_a, tx_count_a, rx_count_a);
        end
        rst = 1'b1;
        @(negedge clk);
        start_run(1'b0);
        wait_done(1'b0, 2000, ok);
        checks++;
        if (!ok || pass_a !== 1'b1 || rx_count_a !== 16'd4) begin
            errors++;
            $display("FAIL midrun rerun: got done=%b pass=%b rx=%0d expected 1/1/4",
                     done_a, pass_a, rx_count_a);
        end
    endtask

`ifdef LINK_SELFTEST_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        ack_gate = 1'b0;
        start_run(1'b0);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (req_out_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n = 0;
        while (ok && timeout_a !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n != 64) begin
            errors++;
            $display("FAIL timeout latency: got %0d cycles expected 64", n);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b0 || led_a !== 1'b0 || req_out_a !== 1'b0
            || ack_out_a !== 1'b0 || timeout_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout status: got done=%b pass=%b req=%b ack=%b to=%b exp 1/0/0/0/1",
                     done_a, pass_a, req_out_a, ack_out_a, timeout_a);
        end
        ack_gate = 1'b1;
        repeat (4) @(negedge clk);
        start_run(1'b0);
        wait_done(1'b0, 2000, ok);
        checks++;
        if (!ok || pass_a !== 1'b1 || timeout_a !== 1'b0) begin
            errors++;
            $display("FAIL timeout rerun: got done=%b pass=%b timeout=%b expected 1/1/0",
                     done_a, pass_a, timeout_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_lfsr();
        test_backpressure();
        test_midrun_reset();
`ifdef LINK_SELFTEST_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
